// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - 4-digit seven-segment scan controller with shadow registers
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZ_BLANK_EN.
module sevenseg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [15:0]   sh_val;
  logic [3:0]    sh_dp;
  logic [3:0]    sh_en;
  logic [3:0]    lz_show;
  logic [3:0]    nib;
  logic [6:0]    dec;
  logic          tick;

  assign tick = (prescaler == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= 2'd0;
    end else if (tick) begin
      prescaler <= '0;
      idx       <= idx + 2'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_val <= 16'h0000;
      sh_dp  <= 4'b0000;
      sh_en  <= 4'b1111;
    end else if (load) begin
      sh_val <= value_in;
      sh_dp  <= dp_in;
      sh_en  <= digit_en;
    end
  end

  always_comb begin
    nib = sh_val[{idx, 2'b00} +: 4];
    dec = 7'h7F;
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
      default: dec = 7'h7F;
    endcase
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  // A digit is shown only if it or any more significant nibble is nonzero.
  always_comb begin
    lz_show[3] = |sh_val[15:12];
    lz_show[2] = |sh_val[15:8];
    lz_show[1] = |sh_val[15:4];
    lz_show[0] = 1'b1;
  end
`else
  assign lz_show = 4'b1111;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else if (tick) begin
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= (idx == 2'd3);
    end else if (sh_en[idx] && lz_show[idx]) begin
      an         <= ~(4'b0001 << idx);
      seg        <= dec;
      dp         <= ~sh_dp[idx];
      frame_done <= 1'b0;
    end else begin
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - directed and random checks of sevenseg_scan_ctrl against a cycle-count model
module tb_sevenseg_scan_ctrl;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  digit_en = 4'b1111;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  int          n;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_en;
  logic [6:0]  dec_tab [16];

  sevenseg_scan_ctrl #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
    .digit_en(digit_en), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_val = 16'h0000;
    m_dp = 4'b0000;
    m_en = 4'b1111;
  endtask

  function automatic logic digit_visible(input int k);
`ifdef SEVENSEG_LZ_BLANK_EN
    return (k == 0) || ((m_val >> (4 * k)) != 16'h0000);
`else
    return 1'b1;
`endif
  endfunction

  // One clock: outputs after edge n follow from the slot position of cycle n and the pre-edge shadow.
  task automatic step(input string tag);
    int pos, slot;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_fd, ld;
    logic [15:0] v;
    logic [3:0] d, en;
    pos = n % R;
    slot = (n / R) % 4;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    if (pos == R - 1) begin
      e_fd = (slot == 3);
    end else if (m_en[slot] && digit_visible(slot)) begin
      e_an = ~(4'b0001 << slot);
      e_seg = dec_tab[(m_val >> (4 * slot)) & 16'hF];
      e_dp = ~m_dp[slot];
    end
    ld = load; v = value_in; d = dp_in; en = digit_en;
    @(posedge clk);
    #1;
    check({tag, ".an"}, {12'h0, an}, {12'h0, e_an});
    check({tag, ".seg"}, {9'h0, seg}, {9'h0, e_seg});
    check({tag, ".dp"}, {15'h0, dp}, {15'h0, e_dp});
    check({tag, ".fd"}, {15'h0, frame_done}, {15'h0, e_fd});
    if (ld) begin
      m_val = v; m_dp = d; m_en = en;
    end
    load = 1'b0;
    n++;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en, input string tag);
    value_in = v; dp_in = d; digit_en = en; load = 1'b1;
    step(tag);
  endtask

  task automatic check_blank(input string tag);
    check({tag, ".an"}, {12'h0, an}, 16'h000F);
    check({tag, ".seg"}, {9'h0, seg}, 16'h007F);
    check({tag, ".dp"}, {15'h0, dp}, 16'h0001);
    check({tag, ".fd"}, {15'h0, frame_done}, 16'h0000);
  endtask

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    model_reset();

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_blank("reset");
    end
    @(negedge clk);
    rst = 1'b0;

    // First edge after release drives digit0 with value 0
    step("first");
    check("first.an_e", {12'h0, an}, 16'h000E);
    check("first.seg_40", {9'h0, seg}, 16'h0040);

    // Directed frame with 1A3F
    do_load(16'h1A3F, 4'b0100, 4'b1111, "ld1a3f");
    for (int i = 0; i < 4 * R + 2; i++) step("frame1a3f");

    // Digits 1 and 3 disabled
    do_load(16'h8888, 4'b0000, 4'b0101, "ld8888");
    for (int i = 0; i < 4 * R + 2; i++) step("en0101");

    // Load coincident with a tick
    for (int i = 0; i < R && (n % R) != R - 1; i++) step("seek_tick");
    do_load(16'h0005, 4'b0000, 4'b1111, "ld_on_tick");
    for (int i = 0; i < 4 * R; i++) step("after_tick_ld");

    // Back-to-back loads, last wins
    do_load(16'h1234, 4'b1111, 4'b1111, "b2b_a");
    do_load(16'hCDEF, 4'b0001, 4'b1111, "b2b_b");
    for (int i = 0; i < 4 * R; i++) step("b2b");

    // Asynchronous reset mid-slot while digit2 is scanned
    for (int i = 0; i < 4 * R && !(((n / R) % 4) == 2 && (n % R) == 1); i++) step("seek_idx2");
    #2;
    rst = 1'b1;
    #1;
    check_blank("async_rst");
    @(posedge clk);
    #1;
    check_blank("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < R + 1; i++) step("resume");

`ifdef SEVENSEG_LZ_BLANK_EN
    do_load(16'h0040, 4'b0000, 4'b1111, "ld0040");
    for (int i = 0; i < 4 * R + 2; i++) step("lz0040");
`endif

    // Randomized loads
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        value_in = 16'($urandom);
        dp_in = 4'($urandom);
        digit_en = 4'($urandom);
        load = 1'b1;
      end
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
